// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the MEM-stage data-memory controller.
package mips_pkg;
  localparam int DATA_W       = 32;
  localparam int DMEM_TIMEOUT = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} dmem_state_e;
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and a variable-latency memory (slave).
interface dmem_if #(parameter int W = 32);
  logic         mem_req_out;
  logic         mem_we_out;
  logic [W-1:0] mem_addr_out;
  logic [W-1:0] mem_wdata_out;
  logic         mem_ack_in;
  logic [W-1:0] mem_rdata_in;

  modport master (output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
                  input  mem_ack_in, mem_rdata_in);
  modport slave  (input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
                  output mem_ack_in, mem_rdata_in);
endinterface

// File: rtl/dmem_access_ctrl_cnt.sv
// Access-timeout counter: clears on a new access, counts waiting cycles, flags the last allowed one.
module dmem_timeout_cnt #(
  parameter int CW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_in,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset_in || clr) cnt_q <= '0;
    else if (en)         cnt_q <= cnt_q + 1'b1;
  end

  assign term = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: stalls the pipeline while a load/store runs over req/ack,
// delivers load data to MEM/WB and records misaligned, illegal or timed-out accesses.
module dmem_access_ctrl
  import mips_pkg::*;
#(
  parameter int n       = DATA_W,
  parameter int TIMEOUT = DMEM_TIMEOUT,
  parameter int CW      = 5
) (
  input  logic         clk,
  input  logic         reset_in,
  input  logic         MemRead_in,
  input  logic         MemWrite_in,
  input  logic [n-1:0] ALU_Result_in,
  input  logic [n-1:0] RT_data_in,
  dmem_if.master       mem,
  output logic         stall_out,
  output logic [n-1:0] Read_Data_out,
  output logic         Read_Data_valid_out,
  output logic         mem_error_out
);
  dmem_state_e state_q, state_d;
  logic op, bad, start, ack_done, tmo, bad_hit, term, cnt_en;

  assign op  = MemRead_in | MemWrite_in;
  assign bad = (MemRead_in & MemWrite_in) | (ALU_Result_in[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Ack wins over timeout when both land on the last allowed cycle.
  always_comb begin
    state_d   = state_q;
    stall_out = 1'b0;
    start     = 1'b0;
    ack_done  = 1'b0;
    tmo       = 1'b0;
    bad_hit   = 1'b0;
    case (state_q)
      IDLE: if (op) begin
        stall_out = 1'b1;
        if (bad) begin
          bad_hit = 1'b1;
          state_d = DONE;
        end else begin
          start   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall_out = 1'b1;
        if (mem.mem_ack_in) begin
          ack_done = 1'b1;
          state_d  = DONE;
        end else if (term) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cnt_en = (state_q == ACCESS) & ~mem.mem_ack_in;

  dmem_timeout_cnt #(.CW(CW), .TIMEOUT(TIMEOUT)) u_cnt (
    .clk      (clk),
    .reset_in (reset_in),
    .clr      (start),
    .en       (cnt_en),
    .term     (term)
  );

  // Address, data and direction are latched once so they stay stable for the whole access.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      mem.mem_req_out     <= 1'b0;
      mem.mem_we_out      <= 1'b0;
      mem.mem_addr_out    <= '0;
      mem.mem_wdata_out   <= '0;
      Read_Data_out       <= '0;
      Read_Data_valid_out <= 1'b0;
      mem_error_out       <= 1'b0;
    end else begin
      Read_Data_valid_out <= ack_done & ~mem.mem_we_out;
      if (start) begin
        mem.mem_req_out   <= 1'b1;
        mem.mem_we_out    <= MemWrite_in;
        mem.mem_addr_out  <= ALU_Result_in;
        mem.mem_wdata_out <= RT_data_in;
      end
      if (ack_done || tmo) mem.mem_req_out <= 1'b0;
      if (ack_done) Read_Data_out <= mem.mem_we_out ? '0 : mem.mem_rdata_in;
      if (tmo || bad_hit) begin
        Read_Data_out <= '0;
        mem_error_out <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: the bench plays the memory and the EX/MEM register.
module tb_dmem_access_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset_in, MemRead_in, MemWrite_in;
  logic [31:0] ALU_Result_in, RT_data_in;
  logic        stall_out, Read_Data_valid_out, mem_error_out;
  logic [31:0] Read_Data_out;
  int          checks = 0, errors = 0, cyc = 0;

  dmem_if #(.W(32)) mif();

  dmem_access_ctrl #(.n(32), .TIMEOUT(16), .CW(5)) dut (
    .clk                 (clk),
    .reset_in            (reset_in),
    .MemRead_in          (MemRead_in),
    .MemWrite_in         (MemWrite_in),
    .ALU_Result_in       (ALU_Result_in),
    .RT_data_in          (RT_data_in),
    .mem                 (mif.master),
    .stall_out           (stall_out),
    .Read_Data_out       (Read_Data_out),
    .Read_Data_valid_out (Read_Data_valid_out),
    .mem_error_out       (mem_error_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Results of the last run_op call
  int          stall_n, req_n, t_start;
  logic        unstable, done_ok, start_req, d_valid, d_err;
  logic [31:0] d_rdata;

  // Presents one op from EX/MEM, acks on the ack_at-th request cycle (0 = never),
  // holds the op through DONE and records what was observed.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int ack_at, input logic [31:0] rdat);
    stall_n = 0; req_n = 0; unstable = 1'b0; done_ok = 1'b0;
    @(negedge clk);
    MemRead_in = rd; MemWrite_in = wr; ALU_Result_in = a; RT_data_in = d;
    mif.mem_ack_in = 1'b0; mif.mem_rdata_in = rdat;
    t_start = cyc;
    #1 start_req = mif.mem_req_out;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (!stall_out) begin
        d_rdata = Read_Data_out; d_valid = Read_Data_valid_out; d_err = mem_error_out;
        done_ok = 1'b1; mif.mem_ack_in = 1'b0;
        break;
      end
      stall_n++;
      if (mif.mem_req_out) begin
        req_n++;
        if (mif.mem_addr_out !== a || mif.mem_wdata_out !== d || mif.mem_we_out !== wr) unstable = 1'b1;
      end
      mif.mem_ack_in = (ack_at != 0) && (req_n == ack_at);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    MemRead_in = 1'b0; MemWrite_in = 1'b0; mif.mem_ack_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    ALU_Result_in = '0; RT_data_in = '0; mif.mem_ack_in = 1'b0; mif.mem_rdata_in = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mif.mem_req_out !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mif.mem_req_out); end
    checks++; if (mif.mem_addr_out !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mif.mem_addr_out); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_out); end
    checks++; if (Read_Data_out !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", Read_Data_out); end
    checks++; if (Read_Data_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", Read_Data_valid_out); end
    checks++; if (mem_error_out !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", mem_error_out); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dut.state_q, IDLE); end
    @(negedge clk); reset_in = 1'b0;
  endtask

  task automatic test_load();
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF);
    checks++; if (done_ok !== 1'b1) begin errors++; $display("FAIL load_done got %b exp 1", done_ok); end
    checks++; if (stall_n != 2) begin errors++; $display("FAIL load_stall got %0d exp 2", stall_n); end
    checks++; if (req_n != 1) begin errors++; $display("FAIL load_req got %0d exp 1", req_n); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL load_addr_we got %b exp 0", unstable); end
    checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", d_rdata); end
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b exp 1", d_valid); end
    go_idle(); #1;
    checks++; if (Read_Data_valid_out !== 1'b0) begin errors++; $display("FAIL load_strobe got %b exp 0", Read_Data_valid_out); end
    checks++; if (Read_Data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hold got %h exp deadbeef", Read_Data_out); end
  endtask

  task automatic test_store();
    run_op(1'b0, 1'b1, 32'h20, 32'h9, 4, 32'h55AA55AA);
    checks++; if (done_ok !== 1'b1) begin errors++; $display("FAIL store_done got %b exp 1", done_ok); end
    checks++; if (req_n != 4) begin errors++; $display("FAIL store_req got %0d exp 4", req_n); end
    checks++; if (stall_n != 5) begin errors++; $display("FAIL store_stall got %0d exp 5", stall_n); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL store_stable got %b exp 0", unstable); end
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL store_valid got %b exp 0", d_valid); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got %h exp 0", d_rdata); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int t0;
    run_op(1'b1, 1'b0, 32'h4, 32'h0, 1, 32'h11112222);
    t0 = t_start;
    checks++; if (req_n != 1 || d_rdata !== 32'h11112222) begin errors++; $display("FAIL b2b_first req %0d data %h exp 1 11112222", req_n, d_rdata); end
    run_op(1'b1, 1'b0, 32'h8, 32'h0, 1, 32'h33334444);
    checks++; if (start_req !== 1'b0) begin errors++; $display("FAIL b2b_reissue got %b exp 0", start_req); end
    checks++; if (req_n != 1 || unstable !== 1'b0) begin errors++; $display("FAIL b2b_second req %0d unstable %b exp 1 0", req_n, unstable); end
    checks++; if (d_rdata !== 32'h33334444 || d_valid !== 1'b1) begin errors++; $display("FAIL b2b_data got %h/%b exp 33334444/1", d_rdata, d_valid); end
    checks++; if (cyc - t0 + 1 != 6) begin errors++; $display("FAIL b2b_cycles got %0d exp 6", cyc - t0 + 1); end
    go_idle();
  endtask

  task automatic test_misaligned();
    run_op(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'hFFFFFFFF);
    checks++; if (req_n != 0) begin errors++; $display("FAIL mis_req got %0d exp 0", req_n); end
    checks++; if (stall_n != 1) begin errors++; $display("FAIL mis_stall got %0d exp 1", stall_n); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL mis_err got %b exp 1", d_err); end
    checks++; if (d_rdata !== 32'h0 || d_valid !== 1'b0) begin errors++; $display("FAIL mis_data got %h/%b exp 0/0", d_rdata, d_valid); end
    go_idle();
    run_op(1'b1, 1'b0, 32'h4, 32'h0, 2, 32'hA5A5A5A5);
    checks++; if (d_rdata !== 32'hA5A5A5A5 || d_valid !== 1'b1) begin errors++; $display("FAIL mis_next got %h/%b exp a5a5a5a5/1", d_rdata, d_valid); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b exp 1", d_err); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemRead_in = 1'b1; ALU_Result_in = 32'h40; mif.mem_ack_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    #1;
    checks++; if (mif.mem_req_out !== 1'b1) begin errors++; $display("FAIL rmid_req_before got %b exp 1", mif.mem_req_out); end
    @(negedge clk);
    reset_in = 1'b0; MemRead_in = 1'b0; mif.mem_ack_in = 1'b1; mif.mem_rdata_in = 32'h77777777;
    #1;
    checks++; if (mif.mem_req_out !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL rmid_req_stall got %b/%b exp 0/0", mif.mem_req_out, stall_out); end
    checks++; if (dut.state_q !== IDLE || mem_error_out !== 1'b0) begin errors++; $display("FAIL rmid_state_err got %0d/%b exp %0d/0", dut.state_q, mem_error_out, IDLE); end
    @(negedge clk); mif.mem_ack_in = 1'b0; #1;
    checks++; if (Read_Data_valid_out !== 1'b0 || Read_Data_out !== 32'h0) begin errors++; $display("FAIL rmid_late_ack got %b/%h exp 0/0", Read_Data_valid_out, Read_Data_out); end
  endtask

  task automatic test_illegal();
    run_op(1'b1, 1'b1, 32'h8, 32'h1, 1, 32'h0);
    checks++; if (req_n != 0 || stall_n != 1 || d_err !== 1'b1) begin errors++; $display("FAIL illegal got req %0d stall %0d err %b exp 0 1 1", req_n, stall_n, d_err); end
    go_idle();
  endtask

  task automatic test_timeout();
    @(negedge clk); reset_in = 1'b1;
    @(negedge clk); reset_in = 1'b0;
    run_op(1'b1, 1'b0, 32'h60, 32'h0, 1, 32'hCAFE0001);
    checks++; if (d_rdata !== 32'hCAFE0001 || d_err !== 1'b0) begin errors++; $display("FAIL tmo_pre got %h/%b exp cafe0001/0", d_rdata, d_err); end
    run_op(1'b1, 1'b0, 32'h64, 32'h0, 0, 32'h12345678);
    checks++; if (done_ok !== 1'b1) begin errors++; $display("FAIL tmo_done got %b exp 1", done_ok); end
    checks++; if (req_n != 16) begin errors++; $display("FAIL tmo_req got %0d exp 16", req_n); end
    checks++; if (stall_n != 17) begin errors++; $display("FAIL tmo_stall got %0d exp 17", stall_n); end
    checks++; if (d_err !== 1'b1 || d_rdata !== 32'h0 || d_valid !== 1'b0) begin errors++; $display("FAIL tmo_result got %b/%h/%b exp 1/0/0", d_err, d_rdata, d_valid); end
    go_idle(); #1;
    checks++; if (dut.state_q !== IDLE || mif.mem_req_out !== 1'b0) begin errors++; $display("FAIL tmo_idle got %0d/%b exp %0d/0", dut.state_q, mif.mem_req_out, IDLE); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    test_illegal();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
